// File: rtl/plic_pkg.sv
// PLIC register map constants and claim-agent state encoding.
package plic_pkg;

  localparam logic [31:0] PLIC_CLAIM_OFFSET  = 32'h0020_0004;
  localparam logic [31:0] PLIC_THRES_OFFSET  = 32'h0020_0000;
  localparam logic [31:0] PLIC_ENABLE_OFFSET = 32'h0000_2000;
  localparam logic [31:0] PLIC_PRI_BASE      = 32'h4;

  typedef enum logic [2:0] {
    IDLE,
    CLAIM_REQ,
    CLAIM_RSP,
    DISPATCH,
    WAIT_DONE,
    COMPLETE_REQ,
    COOLDOWN
  } plic_agent_state_e;

  // Claim/complete register address for a PLIC instance at base.
  function automatic logic [31:0] plic_claim_addr(input logic [31:0] base);
    return base + PLIC_CLAIM_OFFSET;
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter: sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk_i,
  input  logic         rstn_i,
  input  logic         inc_i,
  output logic [W-1:0] cnt_o
);

  localparam logic [W-1:0] One = W'(1);

  // Increment on request unless already at the ceiling.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i)                   cnt_o <= '0;
    else if (inc_i && cnt_o != '1) cnt_o <= cnt_o + One;
  end

endmodule

// File: rtl/plic_claim_agent.sv
// Hardware claim/complete initiator: claims an ID from the PLIC on
// notification, hands it to a consumer, and writes it back on done.
module plic_claim_agent
  import plic_pkg::*;
#(
  parameter logic [31:0] BaseAddr       = 32'h0C00_0000,
  parameter int          IntrIdW        = 6,
  parameter int          CooldownCycles = 3
) (
  input  logic               clk_i,
  input  logic               rstn_i,
  input  logic               enable_i,
  input  logic               irq_external_i,
  output logic               reg_en_o,
  output logic               reg_we_o,
  output logic [31:0]        reg_addr_o,
  output logic [31:0]        reg_wdata_o,
  input  logic [31:0]        reg_rdata_i,
  input  logic               reg_ready_i,
  output logic               irq_valid_o,
  output logic [IntrIdW-1:0] irq_id_o,
  input  logic               irq_ready_i,
  input  logic               done_valid_i,
  input  logic [IntrIdW-1:0] done_id_i,
  output logic               busy_o,
  output logic [15:0]        claim_cnt_o,
  output logic [15:0]        spurious_cnt_o,
  output logic               err_mismatch_o
);

  localparam logic [31:0] ClaimAddr = plic_claim_addr(BaseAddr);
  localparam logic [3:0]  CoolLast  = 4'(CooldownCycles - 1);

  plic_agent_state_e  state_q, state_d;
  logic [IntrIdW-1:0] id_q;
  logic [3:0]         cool_q;
  logic               err_q;
  logic [IntrIdW-1:0] rsp_id;
  logic               rdata_unused;

  // Only the low ID bits of the claim read are meaningful.
  assign rsp_id       = reg_rdata_i[IntrIdW-1:0];
  assign rdata_unused = ^reg_rdata_i[31:IntrIdW];

  // State register; async reset abandons any in-flight service.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) state_q <= IDLE;
    else         state_q <= state_d;
  end

  // Next-state logic; enable_i only gates leaving IDLE.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:         if (enable_i && irq_external_i) state_d = CLAIM_REQ;
      CLAIM_REQ:    if (reg_ready_i)                state_d = CLAIM_RSP;
      CLAIM_RSP:    state_d = (rsp_id == '0) ? COOLDOWN : DISPATCH;
      DISPATCH:     if (irq_ready_i)                state_d = WAIT_DONE;
      WAIT_DONE:    if (done_valid_i)               state_d = COMPLETE_REQ;
      COMPLETE_REQ: if (reg_ready_i)                state_d = COOLDOWN;
      COOLDOWN:     if (cool_q == CoolLast)         state_d = IDLE;
      default:      state_d = IDLE;
    endcase
  end

  // Latch the claimed ID; it drives both dispatch and completion data.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i)                                  id_q <= '0;
    else if (state_q == CLAIM_RSP && rsp_id != '0) id_q <= rsp_id;
  end

  // Cooldown timer restarts from zero on every entry to COOLDOWN.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i)                  cool_q <= '0;
    else if (state_q == COOLDOWN) cool_q <= cool_q + 4'd1;
    else                          cool_q <= '0;
  end

  // Sticky flag when the consumer completes an ID other than the one held.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) err_q <= 1'b0;
    else if (state_q == WAIT_DONE && done_valid_i && done_id_i != id_q) err_q <= 1'b1;
  end

  sat_counter #(.W(16)) u_claim_cnt (
    .clk_i  (clk_i),
    .rstn_i (rstn_i),
    .inc_i  (state_q == CLAIM_RSP && rsp_id != '0),
    .cnt_o  (claim_cnt_o)
  );

  sat_counter #(.W(16)) u_spurious_cnt (
    .clk_i  (clk_i),
    .rstn_i (rstn_i),
    .inc_i  (state_q == CLAIM_RSP && rsp_id == '0),
    .cnt_o  (spurious_cnt_o)
  );

  // Outputs are decoded from the state register, so the bus request is
  // naturally held stable while reg_ready_i is low.
  assign reg_en_o       = (state_q == CLAIM_REQ) || (state_q == COMPLETE_REQ);
  assign reg_we_o       = (state_q == COMPLETE_REQ);
  assign reg_addr_o     = reg_en_o ? ClaimAddr : 32'h0;
  assign reg_wdata_o    = reg_we_o ? 32'(id_q) : 32'h0;
  assign irq_valid_o    = (state_q == DISPATCH);
  assign irq_id_o       = id_q;
  assign busy_o         = (state_q != IDLE);
  assign err_mismatch_o = err_q;

endmodule
